led_matrix_scanner: RTL and testbench

//  Downstream consumer of the physics stage's 256-bit pixel matrix.
//  Row-multiplexes the 16x16 frame onto the LED panel: per row, serially

---
 rtl/led_matrix_scanner.sv | 192 +++++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
`timescale 1ns/1ps
// led_matrix_scanner
//   Row-multiplexes a 16x16 one-bit frame onto an LED panel with a column
//   shift register. For each row, 16 column bits are shifted out (column 15
//   first), then latched. The row is then lit for ROW_HOLD cycles. The input
//   matrix is snapshotted at the start of each frame, so a frame never tears.
//
//   Parameters
//     CLK_DIV   system clocks per sclk half-period (>= 1)
//     ROW_HOLD  system clocks each row is lit with oe_n low (>= 1)
//
//   Ports
//     clk         system clock; all logic runs on its rising edge
//     reset       asynchronous, active-low reset
//     matrix      pixel (x,y) = matrix[y*16+x]; 1 = lit
//     sclk        column shift clock; the panel samples sdata on its rising edge
//     sdata       column serial data
//     slatch      column storage latch strobe, active high
//     oe_n        panel output enable, active low
//     row         row select (index of the row being driven)
//     frame_done  one-cycle pulse after the hold of row 15 completes
module led_matrix_scanner #(
  parameter int CLK_DIV  = 2,
  parameter int ROW_HOLD = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] matrix,
  output logic         sclk,
  output logic         sdata,
  output logic         slatch,
  output logic         oe_n,
  output logic [3:0]   row,
  output logic         frame_done
);

  // One phase counter serves every timed state; it is sized for the longest
  // phase (one shifted bit or the row hold).
  localparam int SHIFT_LEN = 2 * CLK_DIV;
  localparam int CNT_MAX   = (SHIFT_LEN > ROW_HOLD) ? SHIFT_LEN : ROW_HOLD;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] SCLK_RISE  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ROW_HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]         bit_reg, bit_next;
  logic [3:0]         row_ptr_reg, row_ptr_next;
  logic [255:0]       frame_buf_reg, frame_buf_next;
  logic [15:0]        shreg_reg, shreg_next;

  logic               sclk_reg, sclk_next;
  logic               sdata_reg, sdata_next;
  logic               slatch_reg, slatch_next;
  logic               oe_n_reg, oe_n_next;
  logic [3:0]         row_reg, row_next;
  logic               frame_done_reg, frame_done_next;
  logic [3:0]         bit_idx;

  // Per-row view of the frame snapshot.
  logic [15:0] row_words [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_row_words
    assign row_words[gi] = frame_buf_reg[gi*16 +: 16];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      row_ptr_reg    <= '0;
      frame_buf_reg  <= '0;
      shreg_reg      <= '0;
      sclk_reg       <= 1'b0;
      sdata_reg      <= 1'b0;
      slatch_reg     <= 1'b0;
      oe_n_reg       <= 1'b1;
      row_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      row_ptr_reg    <= row_ptr_next;
      frame_buf_reg  <= frame_buf_next;
      shreg_reg      <= shreg_next;
      sclk_reg       <= sclk_next;
      sdata_reg      <= sdata_next;
      slatch_reg     <= slatch_next;
      oe_n_reg       <= oe_n_next;
      row_reg        <= row_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state, counters and datapath.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    row_ptr_next   = row_ptr_reg;
    frame_buf_next = frame_buf_reg;
    shreg_next     = shreg_reg;
    case (state_reg)
      IDLE: state_next = LOAD;
      LOAD: begin
        // Row 0 takes a fresh snapshot; later rows read the snapshot.
        if (row_ptr_reg == 4'd0) begin
          frame_buf_next = matrix;
          shreg_next     = matrix[15:0];
        end else begin
          shreg_next = row_words[row_ptr_reg];
        end
        cnt_next   = '0;
        bit_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == SHIFT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd15) begin
            bit_next   = '0;
            state_next = LATCH;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_reg == LATCH_LAST) begin
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next     = '0;
          row_ptr_next = row_ptr_reg + 4'd1;
          state_next   = LOAD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered pins line
  // up cycle-for-cycle with the state they belong to.
  always_comb begin
    sclk_next       = 1'b0;
    sdata_next      = 1'b0;
    slatch_next     = 1'b0;
    oe_n_next       = 1'b1;
    row_next        = row_reg;
    frame_done_next = 1'b0;
    bit_idx         = 4'd15 - bit_next;
    case (state_next)
      SHIFT: begin
        sdata_next = shreg_next[bit_idx];
        sclk_next  = (cnt_next >= SCLK_RISE);
      end
      LATCH:   slatch_next = 1'b1;
      HOLD:    oe_n_next   = 1'b0;
      default: ;
    endcase
    if (state_reg == SHIFT && state_next == LATCH) begin
      row_next = row_ptr_reg;
    end
    if (state_reg == HOLD && state_next == LOAD && row_ptr_reg == 4'd15) begin
      frame_done_next = 1'b1;
    end
  end

  assign sclk       = sclk_reg;
  assign sdata      = sdata_reg;
  assign slatch     = slatch_reg;
  assign oe_n       = oe_n_reg;
  assign row        = row_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
`timescale 1ns/1ps
// Testbench for led_matrix_scanner. The stimulus pushes the expected row
// records (row index and shifted word) for each frame. A monitor rebuilds
// each row from the panel pins, then pops the queue and compares. A second
// instance runs with CLK_DIV=1 and ROW_HOLD=1 to check the short timing.
module tb_led_matrix_scanner;

  localparam int EXP_FRAME    = 2672;  // 16 * (1 + 33*2 + 100)
  localparam int EXP_LATCH    = 2;
  localparam int EXP_HOLD     = 100;
  localparam int EXP_BIT_GAP  = 4;     // sclk rise-to-rise, 2*CLK_DIV
  localparam int EXP_ROW_T6   = 35;    // 1 + 33*1 + 1
  localparam int EXP_FRAME_T6 = 560;

  typedef struct packed {
    logic [3:0]  row;
    logic [15:0] word;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, reset_b;
  logic [255:0] matrix, matrix_b;
  logic         sclk, sdata, slatch, oe_n, frame_done;
  logic [3:0]   row;
  logic         sclk_b, sdata_b, slatch_b, oe_n_b, frame_done_b;
  logic [3:0]   row_b;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t6_fd_seen = 0;

  logic [15:0] w_t2 [16];
  logic [15:0] w_zero [16];
  logic [15:0] w_ones [16];
  logic [15:0] w_diag [16];
  logic [15:0] w_t1 [16];

  always #5 clk = ~clk;

  led_matrix_scanner #(.CLK_DIV(2), .ROW_HOLD(100)) dut (
    .clk(clk), .reset(reset), .matrix(matrix),
    .sclk(sclk), .sdata(sdata), .slatch(slatch), .oe_n(oe_n),
    .row(row), .frame_done(frame_done)
  );

  led_matrix_scanner #(.CLK_DIV(1), .ROW_HOLD(1)) dut_fast (
    .clk(clk), .reset(reset_b), .matrix(matrix_b),
    .sclk(sclk_b), .sdata(sdata_b), .slatch(slatch_b), .oe_n(oe_n_b),
    .row(row_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"},       32'(sclk),       32'd0);
    chk({tag, "_sdata"},      32'(sdata),      32'd0);
    chk({tag, "_slatch"},     32'(slatch),     32'd0);
    chk({tag, "_oe_n"},       32'(oe_n),       32'd1);
    chk({tag, "_row"},        32'(row),        32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic push_frame(input logic [15:0] w [16]);
    exp_t e;
    for (int y = 0; y < 16; y++) begin
      e.row  = 4'(y);
      e.word = w[y];
      exp_q.push_back(e);
    end
    $display("push frame: row0=%04h row15=%04h", w[0], w[15]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse, expected one within 3000 cycles");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  // Main monitor: rebuilds each row from the pins and scores it.
  initial begin : monitor
    logic        prev_sclk, prev_sdata, prev_slatch, prev_oe;
    logic [15:0] word;
    logic [3:0]  lat_row;
    logic        bad, done_now, fd_valid;
    int          nbits, since_rise, latch_len, hold_len, cyc, last_fd;
    exp_t        e;
    prev_sclk = 0; prev_sdata = 0; prev_slatch = 0; prev_oe = 1;
    word = '0; lat_row = '0; bad = 0; fd_valid = 0;
    nbits = 0; since_rise = 0; latch_len = 0; hold_len = 0; cyc = 0; last_fd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_sclk = 0; prev_sdata = 0; prev_slatch = 0; prev_oe = 1;
        word = '0; lat_row = '0; bad = 0; fd_valid = 0;
        nbits = 0; since_rise = 0; latch_len = 0; hold_len = 0;
      end else begin
        done_now = 0;
        since_rise++;
        if (sclk) begin
          // data must not move while sclk is high or on its rising edge
          if (sdata !== prev_sdata) bad = 1;
          if (oe_n !== 1'b1) bad = 1;
        end
        if (sclk && !prev_sclk) begin
          if (nbits > 0 && since_rise != EXP_BIT_GAP) bad = 1;
          since_rise = 0;
          word = {word[14:0], sdata};
          nbits++;
        end
        if (slatch) begin
          if (!prev_slatch) lat_row = row;
          else if (row !== lat_row) bad = 1;
          if (oe_n !== 1'b1 || sclk) bad = 1;
          if (nbits != 16) bad = 1;
          latch_len++;
        end
        if (!oe_n) begin
          hold_len++;
          if (row !== lat_row || slatch || sclk) bad = 1;
        end
        if (oe_n && !prev_oe) begin
          done_now = 1;
          chk("row_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("row %0d: word=%04h bits=%0d latch=%0d hold=%0d (exp row %0d word %04h)",
                     lat_row, word, nbits, latch_len, hold_len, e.row, e.word);
            chk("row_index",    32'(lat_row),   32'(e.row));
            chk("row_word",     32'(word),      32'(e.word));
            chk("bit_count",    32'(nbits),     32'd16);
            chk("latch_cycles", 32'(latch_len), 32'(EXP_LATCH));
            chk("hold_cycles",  32'(hold_len),  32'(EXP_HOLD));
            chk("waveform_ok",  32'(bad),       32'd0);
          end
          chk("frame_done_at_row_end", 32'(frame_done), 32'(lat_row == 4'd15));
          word = '0; bad = 0; nbits = 0; since_rise = 0; latch_len = 0; hold_len = 0;
        end
        if (frame_done) begin
          chk("frame_done_aligned", 32'(done_now), 32'd1);
          if (fd_valid) chk("frame_period", 32'(cyc - last_fd), 32'(EXP_FRAME));
          last_fd = cyc;
          fd_valid = 1;
        end
        prev_sclk = sclk; prev_sdata = sdata; prev_slatch = slatch; prev_oe = oe_n;
      end
    end
  end

  // Monitor for the fast instance (CLK_DIV=1, ROW_HOLD=1, matrix all ones).
  initial begin : monitor_fast
    logic        p_sclk, p_slatch;
    logic [15:0] word_b;
    int          cyc, last_latch, first_rise, last_rise, rises, latch_seen, fd_last;
    p_sclk = 0; p_slatch = 0; word_b = '0;
    cyc = 0; last_latch = 0; first_rise = 0; last_rise = 0; rises = 0; latch_seen = 0; fd_last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_b) begin
        if (sclk_b && !p_sclk) begin
          if (rises == 0) first_rise = cyc;
          last_rise = cyc;
          rises++;
          word_b = {word_b[14:0], sdata_b};
        end
        if (slatch_b && !p_slatch) begin
          if (latch_seen > 0 && latch_seen <= 5) begin
            $display("fast row %0d: period=%0d sclk_span=%0d rises=%0d word=%04h",
                     row_b, cyc - last_latch, last_rise - first_rise, rises, word_b);
            chk("t6_row_period", 32'(cyc - last_latch),        32'(EXP_ROW_T6));
            chk("t6_sclk_span",  32'(last_rise - first_rise),  32'd30);
            chk("t6_sclk_rises", 32'(rises),                   32'd16);
            chk("t6_row",        32'(row_b),                   32'(latch_seen % 16));
            chk("t6_word",       32'(word_b),                  32'hFFFF);
            chk("t6_oe_blank",   32'(oe_n_b),                  32'd1);
          end
          last_latch = cyc;
          latch_seen++;
          rises = 0;
        end
        if (frame_done_b) begin
          if (t6_fd_seen > 0 && t6_fd_seen <= 3) begin
            $display("fast frame: period=%0d", cyc - fd_last);
            chk("t6_frame_period", 32'(cyc - fd_last), 32'(EXP_FRAME_T6));
          end
          fd_last = cyc;
          t6_fd_seen++;
        end
        p_sclk = sclk_b;
        p_slatch = slatch_b;
      end
    end
  end

  initial begin : stimulus
    logic [255:0] m_diag, m_t1;
    reset = 1'b0;
    reset_b = 1'b0;
    matrix = 256'h1;
    matrix_b = '1;
    for (int y = 0; y < 16; y++) begin
      w_zero[y] = 16'h0000;
      w_ones[y] = 16'hFFFF;
      w_t2[y]   = (y == 0) ? 16'h0001 : 16'h0000;
      w_diag[y] = 16'h0001 << y;
      w_t1[y]   = (y == 0) ? 16'hA5C3 : ((y == 15) ? 16'h1234 : 16'h0000);
    end
    m_diag = '0;
    for (int y = 0; y < 16; y++) m_diag[y*16 + y] = 1'b1;
    m_t1 = '0;
    m_t1[15:0]    = 16'hA5C3;
    m_t1[255:240] = 16'h1234;

    wait_cycles(3);
    chk_reset_outputs("por");
    reset = 1'b1;
    reset_b = 1'b1;

    push_frame(w_t2);                                        // single pixel (0,0)
    wait_fd();
    push_frame(w_t2); wait_cycles(10); matrix = '1;          // change not seen this frame
    wait_fd();
    push_frame(w_ones);
    wait_fd();
    push_frame(w_ones); wait_cycles(10); matrix = '0;
    wait_fd();
    push_frame(w_zero); wait_cycles(5*167 + 20); matrix = '1;  // change during row 5
    wait_fd();
    push_frame(w_ones); wait_cycles(10); matrix = m_diag;
    wait_fd();
    push_frame(w_diag);
    wait_fd();

    // Reset during the row 0 shift: outputs must blank immediately.
    push_frame(w_diag);
    wait_cycles(20);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("mid_shift");
    exp_q.delete();
    matrix = m_t1;
    wait_cycles(3);
    reset = 1'b1;
    push_frame(w_t1);
    wait_fd();
    wait_cycles(2);

    chk("queue_drained",  32'(exp_q.size()),     32'd0);
    chk("t6_frames_seen", 32'(t6_fd_seen >= 4),  32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
